simon_seq_engine: RTL and testbench
===================================

SIMON_SEQ_ENGINE -- requirements
Module: simon_seq_engine

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL expose these parameters, one per line (name, default, meaning):
- NUM_PLAYERS, 2, players taking turns (1..8)
- MAX_LEN, 32, maximum sequence length (2..64)
- COLOR_W, 2, color index width; color 0:Green, 1:Yellow, 2:Red, 3:Blue
- SCORE_W, 8, per-player score width
- TIMEOUT_CYC, 1000, idle cycles allowed per user entry
- SEED, 16'hACE1, LFSR reset value (must be nonzero)
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  pulse; starts a game from IDLE or OVER
- abort  in  1  synchronous return to IDLE
- out_valid  out  1  playback color valid
- out_ready  in  1  display accepted playback color
- out_color  out  COLOR_W  playback color
- in_valid  in  1  user color entry strobe
- in_color  in  COLOR_W  user color
- ready  out  1  high in IDLE
- correct  out  1  one-cycle pulse when a round is completed correctly
- error  out  1  one-cycle pulse on a wrong entry or a timeout
- game_over  out  1  high in OVER
- cur_player  out  $clog2(NUM_PLAYERS) or 1  player whose turn it is
- seq_len  out  $clog2(MAX_LEN+1)  current sequence length
- scores  out  NUM_PLAYERS*SCORE_W  flattened scores; player p occupies [p*SCORE_W +: SCORE_W]

Function
REQ-004 The block SHALL run a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1).
- It shifts every cycle, including in IDLE.
- The new color SHALL be lfsr[COLOR_W-1:0].
REQ-005 The block SHALL implement exactly the states IDLE, EXTEND, PLAY, WAIT_IN and OVER.
REQ-006 IDLE behaviour:
- ready=1.
- start=1 clears all scores, seq_len and cur_player to 0, then goes to EXTEND.
REQ-007 EXTEND behaviour (one cycle):
- If seq_len==MAX_LEN, go to OVER (win).
- Otherwise write the new color at index seq_len, increment seq_len, clear pos and go to PLAY.
REQ-008 PLAY behaviour:
- out_valid=1 and out_color=seq[pos].
- On out_valid&&out_ready, pos increments.
- When the transfer at pos==seq_len-1 completes, pos clears and the state goes to WAIT_IN.
- out_color SHALL hold stable while out_valid=1 and out_ready=0.
REQ-009 WAIT_IN matching:
- in_valid with in_color==seq[pos] increments pos and reloads the timeout counter.
- If that match was at pos==seq_len-1, the block next cycle:
  - pulses correct,
  - increments scores[cur_player], saturating at 2**SCORE_W-1,
  - advances cur_player modulo NUM_PLAYERS,
  - goes to EXTEND.
REQ-010 WAIT_IN failure:
- A mismatch, or TIMEOUT_CYC consecutive cycles without in_valid, pulses error and goes to OVER.
- cur_player is retained in OVER and identifies the loser.
REQ-011 OVER behaviour:
- game_over=1 and scores are held.
- start restarts exactly as from IDLE.
REQ-012 Ignored inputs:
- in_valid outside WAIT_IN SHALL be ignored.
- start outside IDLE/OVER SHALL be ignored.
REQ-013 abort SHALL take priority over every other input and SHALL go to IDLE next cycle without clearing scores; out_valid drops immediately.
REQ-014 correct and error SHALL never assert in the same cycle; every output SHALL be registered.
REQ-015 Sequence storage SHALL be MAX_LEN x COLOR_W registers and SHALL NOT be reset.

Reset
REQ-016 While rst_n=0 the block SHALL hold:
- state=IDLE, lfsr=SEED,
- seq_len=0, pos=0, cur_player=0, scores=0,
- out_valid=0, correct=0, error=0, game_over=0,
- ready=1.
REQ-017 Reset asserted mid-game SHALL abandon the game at once; the first active cycle after release SHALL be in IDLE.

Verification
REQ-018 Reset, then start, with out_ready=1 -> seq_len=1, one out_valid beat, then WAIT_IN; echo that color -> correct pulse, scores[0]=1, cur_player=1.
REQ-019 Hold out_ready=0 for 5 cycles in PLAY -> out_valid=1 and out_color unchanged throughout.
REQ-020 Round with seq_len=3, wrong color at pos 1 -> error pulse, game_over=1, cur_player unchanged, scores unchanged.
REQ-021 TIMEOUT_CYC=10 with no in_valid -> error on the 10th idle cycle, then OVER.
REQ-022 MAX_LEN=2, NUM_PLAYERS=1, two correct rounds -> scores[0]=2, OVER reached with error never asserted.
REQ-023 Assert abort in PLAY, and separately rst_n=0 in WAIT_IN -> ready=1 next cycle; scores kept after abort and zeroed after reset.

Source files
------------

// File: rtl/simon_seq_engine.sv
// simon_seq_engine
//   "Simon" memory game sequencer. A free-running 16-bit LFSR supplies a new
//   random color each round. The stored sequence is replayed through a
//   valid/ready stream. The current player must then echo it back on in_valid
//   within a per-entry timeout. Correct rounds score for the player whose turn
//   it was and pass the turn on. A wrong entry or a timeout ends the game.
//   Filling MAX_LEN entries is a win.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             start a game (accepted in IDLE or OVER only)
//   abort             return to IDLE next cycle; scores are kept
//   out_valid/ready   playback stream handshake, out_color = color index
//   in_valid/in_color user entry strobe and color (used in WAIT_IN only)
//   ready             high while idle
//   correct, error    single-cycle round result pulses
//   game_over         high while in OVER
//   cur_player        whose turn it is (identifies the loser in OVER)
//   seq_len           current sequence length
//   scores            per-player scores, player p at [p*SCORE_W +: SCORE_W]
module simon_seq_engine #(
  parameter int          NUM_PLAYERS = 2,
  parameter int          MAX_LEN     = 32,
  parameter int          COLOR_W     = 2,
  parameter int          SCORE_W     = 8,
  parameter int          TIMEOUT_CYC = 1000,
  parameter logic [15:0] SEED        = 16'hACE1,
  localparam int         PW          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int         LW          = $clog2(MAX_LEN + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [COLOR_W-1:0]             out_color,
  input  logic                           in_valid,
  input  logic [COLOR_W-1:0]             in_color,
  output logic                           ready,
  output logic                           correct,
  output logic                           error,
  output logic                           game_over,
  output logic [PW-1:0]                  cur_player,
  output logic [LW-1:0]                  seq_len,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PW-1:0]      LAST_PLAYER  = PW'(NUM_PLAYERS - 1);
  localparam logic [TW-1:0]      TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0]      MAX_LEN_L    = LW'(MAX_LEN);
  localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXTEND,
    S_PLAY,
    S_WAIT_IN,
    S_OVER
  } state_t;

  state_t             state_reg;
  logic [15:0]        lfsr_reg;
  logic [COLOR_W-1:0] seq_reg [MAX_LEN];
  logic [IW-1:0]      pos_reg;
  logic [LW-1:0]      seq_len_reg;
  logic [PW-1:0]      cur_player_reg;
  logic [TW-1:0]      timer_reg;
  logic               out_valid_reg;
  logic [COLOR_W-1:0] out_color_reg;
  logic               ready_reg;
  logic               correct_reg;
  logic               error_reg;
  logic               game_over_reg;

  logic [COLOR_W-1:0] new_color;
  logic [COLOR_W-1:0] cur_color;
  logic [LW-1:0]      last_idx;
  logic               at_last;
  logic [IW-1:0]      pos_inc;
  logic               can_start;
  logic               seq_we;
  logic               round_done;
  logic               score_clr;

  assign new_color  = lfsr_reg[COLOR_W-1:0];
  assign cur_color  = seq_reg[pos_reg];
  assign last_idx   = seq_len_reg - LW'(1);
  assign at_last    = (LW'(pos_reg) == last_idx);
  assign pos_inc    = pos_reg + IW'(1);
  assign can_start  = start && ((state_reg == S_IDLE) || (state_reg == S_OVER));
  assign seq_we     = !abort && (state_reg == S_EXTEND) && (seq_len_reg != MAX_LEN_L);
  assign round_done = !abort && (state_reg == S_WAIT_IN) && in_valid &&
                      (in_color == cur_color) && at_last;
  assign score_clr  = !abort && can_start;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1 (taps 0,2,3,5).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
    end
  end

  // Sequence memory is deliberately not reset; entries beyond seq_len are
  // never read before being written.
  always_ff @(posedge clk) begin
    if (seq_we) begin
      seq_reg[seq_len_reg[IW-1:0]] <= new_color;
    end
  end

  // Per-player saturating score counters.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_score
      logic [SCORE_W-1:0] score_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          score_reg <= '0;
        end else if (score_clr) begin
          score_reg <= '0;
        end else if (round_done && (cur_player_reg == PW'(gi)) && (score_reg != SCORE_MAX)) begin
          score_reg <= score_reg + SCORE_W'(1);
        end
      end

      assign scores[gi*SCORE_W +: SCORE_W] = score_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      seq_len_reg    <= '0;
      pos_reg        <= '0;
      cur_player_reg <= '0;
      timer_reg      <= '0;
      out_valid_reg  <= 1'b0;
      out_color_reg  <= '0;
      ready_reg      <= 1'b1;
      correct_reg    <= 1'b0;
      error_reg      <= 1'b0;
      game_over_reg  <= 1'b0;
    end else begin
      correct_reg <= 1'b0;
      error_reg   <= 1'b0;
      if (abort) begin
        state_reg     <= S_IDLE;
        pos_reg       <= '0;
        out_valid_reg <= 1'b0;
        ready_reg     <= 1'b1;
        game_over_reg <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE, S_OVER: begin
            if (start) begin
              seq_len_reg    <= '0;
              cur_player_reg <= '0;
              pos_reg        <= '0;
              ready_reg      <= 1'b0;
              game_over_reg  <= 1'b0;
              state_reg      <= S_EXTEND;
            end
          end

          S_EXTEND: begin
            if (seq_len_reg == MAX_LEN_L) begin
              game_over_reg <= 1'b1;
              state_reg     <= S_OVER;
            end else begin
              seq_len_reg   <= seq_len_reg + LW'(1);
              pos_reg       <= '0;
              out_valid_reg <= 1'b1;
              // Entry 0 is being written this very cycle on the first round,
              // so bypass the memory for it.
              out_color_reg <= (seq_len_reg == '0) ? new_color : seq_reg[0];
              state_reg     <= S_PLAY;
            end
          end

          S_PLAY: begin
            if (out_ready) begin
              if (at_last) begin
                pos_reg       <= '0;
                timer_reg     <= '0;
                out_valid_reg <= 1'b0;
                state_reg     <= S_WAIT_IN;
              end else begin
                // Preload the next color so out_color is a pure register.
                pos_reg       <= pos_inc;
                out_color_reg <= seq_reg[pos_inc];
              end
            end
          end

          S_WAIT_IN: begin
            if (in_valid) begin
              timer_reg <= '0;
              if (in_color == cur_color) begin
                if (at_last) begin
                  pos_reg        <= '0;
                  correct_reg    <= 1'b1;
                  cur_player_reg <= (cur_player_reg == LAST_PLAYER) ? '0 : cur_player_reg + PW'(1);
                  state_reg      <= S_EXTEND;
                end else begin
                  pos_reg <= pos_inc;
                end
              end else begin
                error_reg     <= 1'b1;
                game_over_reg <= 1'b1;
                state_reg     <= S_OVER;
              end
            end else if (timer_reg == TIMEOUT_LAST) begin
              error_reg     <= 1'b1;
              game_over_reg <= 1'b1;
              state_reg     <= S_OVER;
            end else begin
              timer_reg <= timer_reg + TW'(1);
            end
          end

          default: begin
            state_reg <= S_IDLE;
            ready_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_color  = out_color_reg;
  assign ready      = ready_reg;
  assign correct    = correct_reg;
  assign error      = error_reg;
  assign game_over  = game_over_reg;
  assign cur_player = cur_player_reg;
  assign seq_len    = seq_len_reg;

endmodule

// File: tb/tb_simon_seq_engine.sv
module tb_simon_seq_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_color = 2'd0;
  logic       sel_b = 1'b0;

  always #5 clk = ~clk;

  // Instance A: two players, MAX_LEN 4, short timeout.
  logic        a_start, a_abort, a_in_valid;
  logic        a_out_valid, a_ready, a_correct, a_error, a_game_over;
  logic [1:0]  a_out_color;
  logic [0:0]  a_cur_player;
  logic [2:0]  a_seq_len;
  logic [15:0] a_scores;

  // Instance B: one player, MAX_LEN 2 (win scenario).
  logic        b_start, b_abort, b_in_valid;
  logic        b_out_valid, b_ready, b_correct, b_error, b_game_over;
  logic [1:0]  b_out_color;
  logic [0:0]  b_cur_player;
  logic [1:0]  b_seq_len;
  logic [7:0]  b_scores;

  assign a_start    = start & ~sel_b;
  assign a_abort    = abort & ~sel_b;
  assign a_in_valid = in_valid & ~sel_b;
  assign b_start    = start & sel_b;
  assign b_abort    = abort & sel_b;
  assign b_in_valid = in_valid & sel_b;

  simon_seq_engine #(
    .NUM_PLAYERS(2), .MAX_LEN(4), .COLOR_W(2), .SCORE_W(8),
    .TIMEOUT_CYC(10), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_color(a_out_color),
    .in_valid(a_in_valid), .in_color(in_color), .ready(a_ready),
    .correct(a_correct), .error(a_error), .game_over(a_game_over),
    .cur_player(a_cur_player), .seq_len(a_seq_len), .scores(a_scores)
  );

  simon_seq_engine #(
    .NUM_PLAYERS(1), .MAX_LEN(2), .COLOR_W(2), .SCORE_W(8),
    .TIMEOUT_CYC(10), .SEED(16'hACE1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_color(b_out_color),
    .in_valid(b_in_valid), .in_color(in_color), .ready(b_ready),
    .correct(b_correct), .error(b_error), .game_over(b_game_over),
    .cur_player(b_cur_player), .seq_len(b_seq_len), .scores(b_scores)
  );

  // Observed outputs of whichever instance is under test.
  logic        o_valid, o_ready, o_correct, o_error, o_over;
  logic [1:0]  o_color;
  logic [0:0]  o_player;
  logic [2:0]  o_seq_len;
  logic [15:0] o_scores;

  assign o_valid   = sel_b ? b_out_valid  : a_out_valid;
  assign o_ready   = sel_b ? b_ready      : a_ready;
  assign o_correct = sel_b ? b_correct    : a_correct;
  assign o_error   = sel_b ? b_error      : a_error;
  assign o_over    = sel_b ? b_game_over  : a_game_over;
  assign o_color   = sel_b ? b_out_color  : a_out_color;
  assign o_player  = sel_b ? b_cur_player : a_cur_player;
  assign o_seq_len = sel_b ? {1'b0, b_seq_len} : a_seq_len;
  assign o_scores  = sel_b ? {8'd0, b_scores}  : a_scores;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, seed ACE1, shifting every cycle.
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  logic b_err_seen = 1'b0;
  always @(posedge clk) if (sel_b && b_error === 1'b1) b_err_seen <= 1'b1;

  // Scoreboard state.
  logic [1:0] seq_m[$];
  logic [1:0] exp_q[$];
  int exp_scores[2];
  int exp_player;
  int exp_len;
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [15:0] exp_scores_vec();
    return {8'(exp_scores[1]), 8'(exp_scores[0])};
  endfunction

  // Called at the falling edge inside the EXTEND cycle.
  task automatic extend_capture();
    seq_m.push_back(lfsr_m[1:0]);
    exp_len++;
    @(negedge clk);
    vectors++;
    if (o_seq_len !== 3'(exp_len)) begin
      miscompares++;
      $display("FAIL seq_len: got %0d expected %0d", o_seq_len, exp_len);
    end
    vectors++;
    if (o_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL out_valid_in_play: got %b expected 1", o_valid);
    end
  endtask

  task automatic start_game();
    seq_m.delete();
    exp_q.delete();
    exp_scores = '{0, 0};
    exp_player = 0;
    exp_len = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (o_scores !== 16'd0 || o_ready !== 1'b0 || o_over !== 1'b0) begin
      miscompares++;
      $display("FAIL start_clear: scores=%h ready=%b over=%b expected 0/0/0", o_scores, o_ready, o_over);
    end
    extend_capture();
  endtask

  task automatic playback(input int stall);
    logic [1:0] exp_c;
    int n;
    foreach (seq_m[i]) exp_q.push_back(seq_m[i]);
    out_ready = (stall == 0);
    for (int k = 0; k < stall; k++) begin
      vectors++;
      if (o_valid !== 1'b1 || o_color !== exp_q[0]) begin
        miscompares++;
        $display("FAIL stall_hold cyc %0d: valid=%b color=%0d expected 1/%0d", k, o_valid, o_color, exp_q[0]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      if (o_valid === 1'b1) begin
        exp_c = exp_q.pop_front();
        vectors++;
        if (o_color !== exp_c) begin
          miscompares++;
          $display("FAIL play_color: got %0d expected %0d", o_color, exp_c);
        end
      end
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL play_timeout: %0d beats missing, expected 0", exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL out_valid_after_play: got %b expected 0", o_valid);
    end
  endtask

  task automatic enter(input int wrong_at, input bit final_round);
    int np;
    np = sel_b ? 1 : 2;
    for (int i = 0; i < seq_m.size(); i++) begin
      in_valid = 1'b1;
      in_color = (i == wrong_at) ? (seq_m[i] ^ 2'b01) : seq_m[i];
      @(negedge clk);
      if (i == wrong_at) break;
    end
    in_valid = 1'b0;
    if (wrong_at >= 0 && wrong_at < seq_m.size()) begin
      vectors++;
      if (o_error !== 1'b1 || o_correct !== 1'b0 || o_over !== 1'b1) begin
        miscompares++;
        $display("FAIL wrong_entry: error=%b correct=%b over=%b expected 1/0/1", o_error, o_correct, o_over);
      end
      vectors++;
      if (o_player !== 1'(exp_player) || o_scores !== exp_scores_vec()) begin
        miscompares++;
        $display("FAIL wrong_keep: player=%0d scores=%h expected %0d/%h", o_player, o_scores, exp_player, exp_scores_vec());
      end
      @(negedge clk);
      vectors++;
      if (o_error !== 1'b0 || o_over !== 1'b1) begin
        miscompares++;
        $display("FAIL error_pulse_end: error=%b over=%b expected 0/1", o_error, o_over);
      end
    end else begin
      exp_scores[exp_player] = (exp_scores[exp_player] == 255) ? 255 : exp_scores[exp_player] + 1;
      exp_player = (exp_player + 1) % np;
      vectors++;
      if (o_correct !== 1'b1 || o_error !== 1'b0) begin
        miscompares++;
        $display("FAIL correct_pulse: correct=%b error=%b expected 1/0", o_correct, o_error);
      end
      vectors++;
      if (o_scores !== exp_scores_vec() || o_player !== 1'(exp_player)) begin
        miscompares++;
        $display("FAIL round_score: scores=%h player=%0d expected %h/%0d", o_scores, o_player, exp_scores_vec(), exp_player);
      end
      if (final_round) begin
        @(negedge clk);
        vectors++;
        if (o_over !== 1'b1 || o_error !== 1'b0 || o_correct !== 1'b0 || o_seq_len !== 3'(exp_len)) begin
          miscompares++;
          $display("FAIL win_over: over=%b error=%b correct=%b len=%0d expected 1/0/0/%0d", o_over, o_error, o_correct, o_seq_len, exp_len);
        end
      end else begin
        extend_capture();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (o_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b expected 1", o_ready); end
    vectors++;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", o_valid); end
    vectors++;
    if (o_correct !== 1'b0 || o_error !== 1'b0) begin miscompares++; $display("FAIL rst_pulses: correct=%b error=%b expected 0/0", o_correct, o_error); end
    vectors++;
    if (o_over !== 1'b0) begin miscompares++; $display("FAIL rst_game_over: got %b expected 0", o_over); end
    vectors++;
    if (o_seq_len !== 3'd0 || o_player !== 1'b0 || o_scores !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_counters: len=%0d player=%0d scores=%h expected 0/0/0", o_seq_len, o_player, o_scores);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready: got %b expected 1", o_ready); end
  endtask

  task automatic test_first_round();
    start_game();
    playback(0);
    enter(-1, 1'b0);
    $display("first_round: scores=%h player=%0d len=%0d", o_scores, o_player, o_seq_len);
  endtask

  task automatic test_stall();
    playback(5);
    enter(-1, 1'b0);
    $display("stall: scores=%h player=%0d len=%0d", o_scores, o_player, o_seq_len);
  endtask

  task automatic test_wrong();
    playback(0);
    enter(1, 1'b0);
    $display("wrong: over=%b player=%0d scores=%h", o_over, o_player, o_scores);
  endtask

  task automatic test_timeout();
    start_game();
    playback(0);
    for (int k = 1; k <= 10; k++) begin
      start = (k == 3);
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (o_error !== (k == 10)) begin
        miscompares++;
        $display("FAIL timeout_error idle %0d: got %b expected %b", k, o_error, (k == 10));
      end
    end
    vectors++;
    if (o_over !== 1'b1 || o_seq_len !== 3'(exp_len)) begin
      miscompares++;
      $display("FAIL timeout_over: over=%b len=%0d expected 1/%0d", o_over, o_seq_len, exp_len);
    end
    $display("timeout: over=%b len=%0d", o_over, o_seq_len);
  endtask

  task automatic test_abort();
    start_game();
    playback(0);
    enter(-1, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_over !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: ready=%b valid=%b over=%b expected 1/0/0", o_ready, o_valid, o_over);
    end
    vectors++;
    if (o_scores !== exp_scores_vec()) begin
      miscompares++;
      $display("FAIL abort_scores: got %h expected %h", o_scores, exp_scores_vec());
    end
    $display("abort: ready=%b scores=%h", o_ready, o_scores);
  endtask

  task automatic test_reset_midgame();
    start_game();
    playback(0);
    enter(-1, 1'b0);
    playback(0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (o_ready !== 1'b1 || o_scores !== 16'd0 || o_player !== 1'b0 || o_seq_len !== 3'd0) begin
      miscompares++;
      $display("FAIL midgame_reset: ready=%b scores=%h player=%0d len=%0d expected 1/0/0/0", o_ready, o_scores, o_player, o_seq_len);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: ready=%b valid=%b expected 1/0", o_ready, o_valid);
    end
    $display("reset_midgame: ready=%b scores=%h", o_ready, o_scores);
  endtask

  task automatic test_win();
    sel_b = 1'b1;
    @(negedge clk);
    start_game();
    playback(0);
    enter(-1, 1'b0);
    playback(0);
    enter(-1, 1'b1);
    vectors++;
    if (b_err_seen !== 1'b0 || o_scores !== 16'd2) begin
      miscompares++;
      $display("FAIL win_clean: error_seen=%b scores=%h expected 0/0002", b_err_seen, o_scores);
    end
    $display("win: over=%b scores=%h", o_over, o_scores);
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_stall();
    test_wrong();
    test_timeout();
    test_abort();
    test_reset_midgame();
    test_win();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
